fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined LEGv8 core. It owns the program counter and drives the word address of the 256×32 instruction ROM (`imem`). It captures the combinational ROM output together with its PC into the IF/ID pipeline register that feeds decode. Stall, flush and branch-redirect inputs come from the hazard unit and the branch-resolution logic.

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, addresses the instruction ROM and captures the
// fetched word plus its PC into the IF/ID register for decode.
module fetch_stage #(
  parameter int N  = 64,
  parameter int IW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_F,
  input  logic          flush_D,
  input  logic          PCSrc,
  input  logic [N-1:0]  PCBranch,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_q,
  output logic [IW-1:0] instr_D,
  output logic [N-1:0]  pc_D,
  output logic          valid_D,
  output logic [31:0]   fetch_count
);

  logic [N-1:0]  pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [N-1:0]  pcd_q, pcd_d;
  logic          valid_q, valid_d;
  logic [31:0]   fetch_count_q, fetch_count_d;
  logic          load_d;

  // Low branch-target bits are dropped so the PC always stays word aligned.
  logic unused_br;
  assign unused_br = &{1'b0, PCBranch[1:0]};

  // Next PC: a redirect outranks a stall so a taken branch is never lost.
  always_comb begin
    pc_d = pc_q + N'(4);
    if (PCSrc)        pc_d = {PCBranch[N-1:2], 2'b00};
    else if (stall_F) pc_d = pc_q;
  end

  // IF/ID next state: a flush outranks a stall; otherwise load the ROM word.
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    valid_d = valid_q;
    load_d  = 1'b0;
    if (flush_D) begin
      instr_d = '0;
      pcd_d   = '0;
      valid_d = 1'b0;
    end else if (!stall_F) begin
      instr_d = imem_q;
      pcd_d   = pc_q;
      valid_d = 1'b1;
      load_d  = 1'b1;
    end
  end

  // Delivered-instruction counter, saturating at all ones.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (load_d && (fetch_count_q != '1)) fetch_count_d = fetch_count_q + 32'd1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= '0;
      instr_q       <= '0;
      pcd_q         <= '0;
      valid_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pcd_q         <= pcd_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q[AW+1:2];
  assign instr_D     = instr_q;
  assign pc_D        = pcd_q;
  assign valid_D     = valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus against a spec-level model of the fetch
// stage, with a per-cycle compare plus hand-computed literal checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_F = 1'b0, flush_D = 1'b0, PCSrc = 1'b0;
  logic [63:0] PCBranch = '0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_q;
  logic [31:0] instr_D;
  logic [63:0] pc_D;
  logic        valid_D;
  logic [31:0] fetch_count;

  logic [31:0] rom [256];
  assign imem_q = rom[imem_addr];

  fetch_stage #(.N(64), .IW(32), .AW(8)) dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .flush_D(flush_D),
    .PCSrc(PCSrc), .PCBranch(PCBranch), .imem_addr(imem_addr),
    .imem_q(imem_q), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state.
  longint unsigned m_pc, m_pcd;
  logic [31:0]     m_instr, m_cnt;
  bit              m_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc imem_addr", {56'd0, imem_addr}, (m_pc >> 2) % 256);
      chk("cyc instr_D", {32'd0, instr_D}, {32'd0, m_instr});
      chk("cyc pc_D", pc_D, m_pcd);
      chk("cyc valid_D", {63'd0, valid_D}, {63'd0, m_valid});
      chk("cyc fetch_count", {32'd0, fetch_count}, {32'd0, m_cnt});
    end
  end

  // Apply one cycle of inputs, advance the model, return at negedge+1.
  task automatic step(input bit r, input bit st, input bit fl, input bit ps,
                      input logic [63:0] br);
    longint unsigned n_pc, n_pcd;
    logic [31:0] n_instr, n_cnt;
    bit n_valid;
    reset = r; stall_F = st; flush_D = fl; PCSrc = ps; PCBranch = br;
    if (!r) begin
      n_pc = 0; n_pcd = 0; n_instr = 0; n_valid = 0; n_cnt = 0;
    end else begin
      n_pc    = ps ? (br / 4) * 4 : (st ? m_pc : m_pc + 4);
      n_pcd   = m_pcd; n_instr = m_instr; n_valid = m_valid; n_cnt = m_cnt;
      if (fl) begin
        n_pcd = 0; n_instr = 0; n_valid = 0;
      end else if (!st) begin
        n_instr = rom[(m_pc / 4) % 256];
        n_pcd   = m_pc;
        n_valid = 1;
        if (m_cnt != 32'hFFFF_FFFF) n_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_pcd = n_pcd; m_instr = n_instr; m_valid = n_valid; m_cnt = n_cnt;
    @(negedge clk);
    #1;
  endtask

  task automatic run(); step(1, 0, 0, 0, 64'd0); endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h8B00_0000 + i;
    rom[0] = 32'hf800_0001;
    rom[1] = 32'hf800_8002;
    rom[2] = 32'hf800_0203;
    m_pc = 0; m_pcd = 0; m_instr = 0; m_valid = 0; m_cnt = 0;

    // Reset held two edges.
    step(0, 0, 0, 0, 64'd0);
    chk_en = 1'b1;
    step(0, 0, 0, 0, 64'd0);
    chk("rst valid_D", {63'd0, valid_D}, 64'd0);
    chk("rst fetch_count", {32'd0, fetch_count}, 64'd0);
    chk("rst pc_D", pc_D, 64'd0);
    chk("rst imem_addr", {56'd0, imem_addr}, 64'd0);

    // Sequential fetch.
    run();
    chk("seq1 instr", {32'd0, instr_D}, 64'hf800_0001);
    chk("seq1 pc", pc_D, 64'd0);
    chk("seq1 addr", {56'd0, imem_addr}, 64'd1);
    run();
    chk("seq2 instr", {32'd0, instr_D}, 64'hf800_8002);
    chk("seq2 pc", pc_D, 64'd4);
    run();
    chk("seq3 instr", {32'd0, instr_D}, 64'hf800_0203);
    chk("seq3 pc", pc_D, 64'd8);
    chk("seq3 count", {32'd0, fetch_count}, 64'd3);
    chk("seq3 valid", {63'd0, valid_D}, 64'd1);
    chk("model count", {32'd0, m_cnt}, 64'd3);
    run();
    chk("seq4 pc", pc_D, 64'hC);

    // Stall three cycles at PC=0x10.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 64'd0);
      chk("stall addr", {56'd0, imem_addr}, 64'd4);
      chk("stall pc_D", pc_D, 64'hC);
      chk("stall instr", {32'd0, instr_D}, 64'h8B00_0003);
      chk("stall count", {32'd0, fetch_count}, 64'd4);
    end
    run();
    chk("unstall pc_D", pc_D, 64'h10);
    chk("unstall count", {32'd0, fetch_count}, 64'd5);

    // Redirect to a misaligned target with flush.
    step(1, 0, 1, 1, 64'h1F6);
    chk("redir addr", {56'd0, imem_addr}, 64'h7D);
    chk("redir valid", {63'd0, valid_D}, 64'd0);
    chk("redir instr", {32'd0, instr_D}, 64'd0);
    chk("redir count", {32'd0, fetch_count}, 64'd5);
    run();
    chk("redir tgt pc_D", pc_D, 64'h1F4);
    chk("model redir pc", m_pcd, 64'h1F4);

    // Redirect during stall, then flush+stall.
    step(1, 1, 0, 1, 64'h20);
    chk("stallredir addr", {56'd0, imem_addr}, 64'd8);
    chk("stallredir pc_D", pc_D, 64'h1F4);
    chk("stallredir count", {32'd0, fetch_count}, 64'd6);
    step(1, 1, 1, 0, 64'd0);
    chk("flushstall valid", {63'd0, valid_D}, 64'd0);
    chk("flushstall pc_D", pc_D, 64'd0);
    chk("flushstall addr", {56'd0, imem_addr}, 64'd8);
    run();
    chk("after flushstall pc_D", pc_D, 64'h20);
    chk("after flushstall count", {32'd0, fetch_count}, 64'd7);

    // Word-address wrap at PC 0x3FC -> 0x400.
    step(1, 0, 0, 1, 64'h3FC);
    chk("wrap addr0", {56'd0, imem_addr}, 64'hFF);
    run();
    chk("wrap addr1", {56'd0, imem_addr}, 64'h00);
    chk("wrap pc_D0", pc_D, 64'h3FC);
    run();
    chk("wrap pc_D1", pc_D, 64'h400);
    chk("wrap count", {32'd0, fetch_count}, 64'd10);

    // Full 64-bit PC wrap.
    step(1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pcwrap addr", {56'd0, imem_addr}, 64'hFF);
    run();
    chk("pcwrap pc_D", pc_D, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("pcwrap addr0", {56'd0, imem_addr}, 64'd0);
    run();
    chk("pcwrap pc_D0", pc_D, 64'd0);

    // Mid-run reset with other inputs active.
    step(0, 0, 0, 1, 64'h100);
    chk("midrst addr", {56'd0, imem_addr}, 64'd0);
    chk("midrst instr", {32'd0, instr_D}, 64'd0);
    chk("midrst pc_D", pc_D, 64'd0);
    chk("midrst valid", {63'd0, valid_D}, 64'd0);
    chk("midrst count", {32'd0, fetch_count}, 64'd0);
    run();
    run();
    chk("post rst count", {32'd0, fetch_count}, 64'd2);

    // Counter saturation: preload just below the ceiling.
    force dut.fetch_count_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_count_q;
    run();
    chk("sat count1", {32'd0, fetch_count}, 64'hFFFF_FFFF);
    run();
    chk("sat count2", {32'd0, fetch_count}, 64'hFFFF_FFFF);
    run();
    chk("sat count3", {32'd0, fetch_count}, 64'hFFFF_FFFF);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
